seq_game_ctrl: RTL and testbench

- Sequencing controller for the 4-button memory-sequence game.
- Generates a pseudo-random pattern and plays the first `lv` steps on the lamps.
- Collects and checks the player's button presses, then advances the level or ends the game with win or fail.
- Paced by a one-clock `tick` strobe from the frequency divider. Replaces the ad-hoc T_FF/decoder sequencing around the level memory.

---
 rtl/seq_game_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_seq_game_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_game_ctrl.sv
// Sequencing controller for the 4-button memory-sequence game: builds an LFSR pattern,
// replays the first lv steps on the lamps, then checks the player's presses.
module seq_game_ctrl #(
  parameter int unsigned MAX_LV      = 8,
  parameter int unsigned SHOW_CYC    = 4,
  parameter int unsigned GAP_CYC     = 2,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter logic [7:0]  SEED        = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic [3:0] b,
  output logic [3:0] lamp,
  output logic [3:0] lv,
  output logic       busy,
  output logic       win,
  output logic       fail
);

  localparam int unsigned MaxCyc =
      (TIMEOUT_CYC > SHOW_CYC) ? ((TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC)
                               : ((SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC);
  localparam int unsigned TmrW = $clog2(MaxCyc + 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StShow, StGap, StInput, StPause, StWin, StFail
  } state_e;

  state_e                  state_q, state_d;
  logic [7:0]              lfsr_q, lfsr_d;
  logic [3:0]              idx_q, idx_d;
  logic [TmrW-1:0]         tmr_q, tmr_d;
  logic [3:0]              lv_q, lv_d;
  logic [3:0]              b_prev_q;
  logic [2*MAX_LV-1:0]     pat_q, pat_d;
  logic [3:0]              lamp_q, lamp_d;
  logic                    busy_q, busy_d;
  logic                    win_q, win_d;
  logic                    fail_q, fail_d;

  logic [3:0] rise;
  logic [3:0] exp_oh;
  logic       last_step;
  logic       lfsr_fb;

  function automatic logic [3:0] onehot(input logic [1:0] p);
    return 4'b0001 << p;
  endfunction

  assign rise      = b & ~b_prev_q;
  assign exp_oh    = onehot(pat_q[{idx_q, 1'b0} +: 2]);
  assign last_step = (idx_q == lv_q - 4'd1);
  assign lfsr_fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    lv_d    = lv_q;
    pat_d   = pat_q;

    unique case (state_q)
      StIdle, StWin, StFail: begin
        if ((state_q != StIdle || start) && start) begin
          state_d = StLoad;
          idx_d   = '0;
          lv_d    = '0;
        end
      end
      StLoad: begin
        // idx doubles as the write pointer while the pattern is built
        pat_d[{idx_q, 1'b0} +: 2] = lfsr_q[1:0];
        lfsr_d = {lfsr_q[6:0], lfsr_fb};
        if (idx_q == 4'(MAX_LV - 1)) begin
          idx_d   = '0;
          lv_d    = 4'd1;
          tmr_d   = '0;
          state_d = StShow;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      StShow: begin
        if (tick) begin
          if (tmr_q == TmrW'(SHOW_CYC - 1)) begin
            tmr_d   = '0;
            state_d = StGap;
          end else begin
            tmr_d = tmr_q + TmrW'(1);
          end
        end
      end
      StGap: begin
        if (tick) begin
          if (tmr_q == TmrW'(GAP_CYC - 1)) begin
            tmr_d = '0;
            if (!last_step) begin
              idx_d   = idx_q + 4'd1;
              state_d = StShow;
            end else begin
              idx_d   = '0;
              state_d = StInput;
            end
          end else begin
            tmr_d = tmr_q + TmrW'(1);
          end
        end
      end
      StInput: begin
        // a press takes priority over a coincident tick
        if (rise != 4'd0) begin
          if (rise == exp_oh && b == exp_oh) begin
            tmr_d = '0;
            if (!last_step) begin
              idx_d = idx_q + 4'd1;
            end else if (lv_q == 4'(MAX_LV)) begin
              state_d = StWin;
            end else begin
              lv_d    = lv_q + 4'd1;
              idx_d   = '0;
              state_d = StPause;
            end
          end else begin
            state_d = StFail;
          end
        end else if (tick) begin
          if (tmr_q == TmrW'(TIMEOUT_CYC - 1)) begin
            state_d = StFail;
          end else begin
            tmr_d = tmr_q + TmrW'(1);
          end
        end
      end
      StPause: begin
        if (tick) begin
          if (tmr_q == TmrW'(GAP_CYC - 1)) begin
            tmr_d   = '0;
            state_d = StShow;
          end else begin
            tmr_d = tmr_q + TmrW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they move on the same edge as the state.
  always_comb begin
    lamp_d = 4'd0;
    busy_d = 1'b0;
    win_d  = 1'b0;
    fail_d = 1'b0;
    unique case (state_d)
      StLoad:  busy_d = 1'b1;
      StShow: begin
        busy_d = 1'b1;
        lamp_d = onehot(pat_d[{idx_d, 1'b0} +: 2]);
      end
      StGap:   busy_d = 1'b1;
      StInput: begin
        busy_d = 1'b1;
        lamp_d = b;
      end
      StPause: busy_d = 1'b1;
      StWin: begin
        win_d  = 1'b1;
        lamp_d = 4'b1111;
      end
      StFail:  fail_d = 1'b1;
      default: lamp_d = 4'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      lfsr_q   <= SEED;
      idx_q    <= '0;
      tmr_q    <= '0;
      lv_q     <= '0;
      b_prev_q <= '0;
      pat_q    <= '0;
      lamp_q   <= '0;
      busy_q   <= 1'b0;
      win_q    <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      idx_q    <= idx_d;
      tmr_q    <= tmr_d;
      lv_q     <= lv_d;
      b_prev_q <= b;
      pat_q    <= pat_d;
      lamp_q   <= lamp_d;
      busy_q   <= busy_d;
      win_q    <= win_d;
      fail_q   <= fail_d;
    end
  end

  assign lamp = lamp_q;
  assign lv   = lv_q;
  assign busy = busy_q;
  assign win  = win_q;
  assign fail = fail_q;

endmodule

// File: tb/tb_seq_game_ctrl.sv
// Directed bench for seq_game_ctrl: a vector table for reset/idle/load/first show,
// then hand-written games covering win, wrong/double press, timeout tie and mid-play reset.
module tb_seq_game_ctrl;

  logic       clk = 1'b0;
  logic       reset, tick, start;
  logic [3:0] b;
  logic [3:0] lamp, lv;
  logic       busy, win, fail;

  int n_chk = 0;
  int n_err = 0;

  logic [1:0] hand_pat [8];
  logic [1:0] cur_pat  [8];
  logic [7:0] m_lfsr;

  typedef struct {
    logic       rst;
    logic       st;
    logic       tk;
    logic [3:0] bb;
    logic [3:0] e_lamp;
    logic [3:0] e_lv;
    logic       e_busy;
    logic       e_win;
    logic       e_fail;
  } vec_t;

  vec_t vecs[$];

  seq_game_ctrl #(
    .MAX_LV      (8),
    .SHOW_CYC    (4),
    .GAP_CYC     (2),
    .TIMEOUT_CYC (64),
    .SEED        (8'hA5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .start (start),
    .b     (b),
    .lamp  (lamp),
    .lv    (lv),
    .busy  (busy),
    .win   (win),
    .fail  (fail)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  function automatic logic [3:0] oh(input logic [1:0] p);
    return 4'b0001 << p;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic step(input logic t, input logic [3:0] bv);
    tick = t;
    b    = bv;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic gen_pat();
    for (int i = 0; i < 8; i++) begin
      cur_pat[i] = m_lfsr[1:0];
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  endtask

  task automatic add(input logic r, input logic s, input logic t, input logic [3:0] el,
                     input logic [3:0] ev, input logic eb, input logic ew, input logic ef);
    vec_t v;
    v.rst = r; v.st = s; v.tk = t; v.bb = 4'd0;
    v.e_lamp = el; v.e_lv = ev; v.e_busy = eb; v.e_win = ew; v.e_fail = ef;
    vecs.push_back(v);
  endtask

  task automatic start_game(input int g);
    start = 1'b1;
    step(1'b0, 4'd0);
    start = 1'b0;
    chk($sformatf("g%0d.load.busy", g), busy, 1);
    chk($sformatf("g%0d.load.lv", g), lv, 0);
    chk($sformatf("g%0d.load.flags", g), {win, fail}, 0);
    repeat (7) step(1'b1, 4'd0);
    chk($sformatf("g%0d.load.last_lv", g), lv, 0);
    step(1'b1, 4'd0);
    chk($sformatf("g%0d.show.lv", g), lv, 1);
  endtask

  // Entered with the DUT having just moved into SHOW for step 0.
  task automatic show_level(input int g, input int level);
    for (int i = 0; i < level; i++) begin
      chk($sformatf("g%0d.l%0d.s%0d.lamp", g, level, i), lamp, oh(cur_pat[i]));
      for (int t = 1; t <= 4; t++) begin
        step(1'b1, 4'd0);
        chk($sformatf("g%0d.l%0d.s%0d.t%0d", g, level, i, t), lamp,
            (t < 4) ? oh(cur_pat[i]) : 4'd0);
      end
      step(1'b1, 4'd0);
      chk($sformatf("g%0d.l%0d.s%0d.gap", g, level, i), lamp, 0);
      step(1'b1, 4'd0);
    end
    chk($sformatf("g%0d.l%0d.input.lamp", g, level), lamp, 0);
    chk($sformatf("g%0d.l%0d.input.busy", g, level), busy, 1);
    chk($sformatf("g%0d.l%0d.input.lv", g, level), lv, level);
  endtask

  task automatic input_level(input int g, input int level);
    for (int i = 0; i < level; i++) begin
      step(1'b0, oh(cur_pat[i]));
      if (i < level - 1) begin
        chk($sformatf("g%0d.l%0d.p%0d.echo", g, level, i), lamp, oh(cur_pat[i]));
        chk($sformatf("g%0d.l%0d.p%0d.fail", g, level, i), fail, 0);
        step(1'b0, 4'd0);
      end else if (level < 8) begin
        chk($sformatf("g%0d.l%0d.up.lv", g, level), lv, level + 1);
        chk($sformatf("g%0d.l%0d.up.lamp", g, level), lamp, 0);
        step(1'b0, 4'd0);
        step(1'b1, 4'd0);
        chk($sformatf("g%0d.l%0d.pause.lamp", g, level), lamp, 0);
        step(1'b1, 4'd0);
      end else begin
        chk($sformatf("g%0d.win", g), win, 1);
        chk($sformatf("g%0d.win.lamp", g), lamp, 4'b1111);
        chk($sformatf("g%0d.win.busy", g), busy, 0);
        chk($sformatf("g%0d.win.lv", g), lv, 8);
        step(1'b0, 4'd0);
      end
    end
  endtask

  initial begin
    logic [1:0] wrong;
    // Pattern from seed A5: lfsr A5,4A,95,2A,54,A9,53,A7 -> low two bits
    hand_pat = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd0, 2'd1, 2'd3, 2'd3};
    m_lfsr   = 8'hA5;
    reset = 1'b0; start = 1'b0; tick = 1'b0; b = 4'd0;
    @(negedge clk);

    add(0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
    add(0, 0, 1, 4'd0, 4'd0, 0, 0, 0);
    for (int i = 0; i < 20; i++) add(1, 0, 1, 4'd0, 4'd0, 0, 0, 0);
    add(1, 1, 0, 4'd0, 4'd0, 1, 0, 0);
    for (int i = 0; i < 7; i++) add(1, 0, 1, 4'd0, 4'd0, 1, 0, 0);
    add(1, 0, 1, 4'b0010, 4'd1, 1, 0, 0);
    for (int t = 1; t <= 4; t++) begin
      add(1, 0, 0, 4'b0010, 4'd1, 1, 0, 0);
      add(1, 0, 1, (t < 4) ? 4'b0010 : 4'd0, 4'd1, 1, 0, 0);
    end
    add(1, 0, 0, 4'd0, 4'd1, 1, 0, 0);
    add(1, 0, 1, 4'd0, 4'd1, 1, 0, 0);
    add(1, 0, 0, 4'd0, 4'd1, 1, 0, 0);
    add(1, 0, 1, 4'd0, 4'd1, 1, 0, 0);

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      start = vecs[i].st;
      step(vecs[i].tk, vecs[i].bb);
      chk($sformatf("vec%0d.lamp", i), lamp, vecs[i].e_lamp);
      chk($sformatf("vec%0d.lv", i), lv, vecs[i].e_lv);
      chk($sformatf("vec%0d.busy", i), busy, vecs[i].e_busy);
      chk($sformatf("vec%0d.win", i), win, vecs[i].e_win);
      chk($sformatf("vec%0d.fail", i), fail, vecs[i].e_fail);
    end
    start = 1'b0;

    // Game 1: full win on the seed pattern
    gen_pat();
    cur_pat = hand_pat;
    input_level(1, 1);
    for (int l = 2; l <= 8; l++) begin
      show_level(1, l);
      input_level(1, l);
    end

    // Game 2: new pattern, wrong press at lv=3 idx=1
    gen_pat();
    start_game(2);
    for (int l = 1; l <= 2; l++) begin
      show_level(2, l);
      input_level(2, l);
    end
    show_level(2, 3);
    step(1'b0, oh(cur_pat[0]));
    step(1'b0, 4'd0);
    chk("g2.idx1.fail_before", fail, 0);
    wrong = cur_pat[1] + 2'd1;
    step(1'b0, oh(wrong));
    chk("g2.wrong.fail", fail, 1);
    chk("g2.wrong.lv", lv, 3);
    chk("g2.wrong.busy", busy, 0);
    chk("g2.wrong.lamp", lamp, 0);
    step(1'b0, 4'd0);

    // Game 3: two buttons rising in the same clk
    gen_pat();
    start_game(3);
    show_level(3, 1);
    wrong = cur_pat[0] + 2'd1;
    step(1'b0, oh(cur_pat[0]) | oh(wrong));
    chk("g3.double.fail", fail, 1);
    chk("g3.double.lv", lv, 1);
    step(1'b0, 4'd0);

    // Game 4: press on the 64th tick clears the timer, then a real timeout
    gen_pat();
    start_game(4);
    show_level(4, 1);
    input_level(4, 1);
    show_level(4, 2);
    repeat (63) step(1'b1, 4'd0);
    chk("g4.t63.fail", fail, 0);
    step(1'b1, oh(cur_pat[0]));
    chk("g4.tie.fail", fail, 0);
    chk("g4.tie.echo", lamp, oh(cur_pat[0]));
    step(1'b0, 4'd0);
    repeat (63) step(1'b1, 4'd0);
    chk("g4.idle63.fail", fail, 0);
    step(1'b1, 4'd0);
    chk("g4.timeout.fail", fail, 1);
    chk("g4.timeout.lv", lv, 2);

    // Game 5: reset in SHOW at lv=5, then the seed pattern again
    gen_pat();
    start_game(5);
    for (int l = 1; l <= 4; l++) begin
      show_level(5, l);
      input_level(5, l);
    end
    chk("g5.show.lv", lv, 5);
    step(1'b1, 4'd0);
    reset = 1'b0;
    start = 1'b1;
    step(1'b1, 4'd0);
    chk("g5.rst.lamp", lamp, 0);
    chk("g5.rst.lv", lv, 0);
    chk("g5.rst.busy", busy, 0);
    chk("g5.rst.flags", {win, fail}, 0);
    reset = 1'b1;
    start = 1'b0;
    step(1'b1, 4'd0);
    chk("g5.idle.busy", busy, 0);
    cur_pat = hand_pat;
    start_game(6);
    for (int l = 1; l <= 8; l++) begin
      show_level(6, l);
      input_level(6, l);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
